// File: rtl/eq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : eq_pkg
// Purpose  : Shared definitions for the histogram-equalizer stages: the
//            counting, CDF and mapping stages all import this package.
// Contents : pass-FSM state enum, bin count, memory widths, CDF width,
//            valid-entry marker for histogram words.
// Revision : 1.0  initial release
// ============================================================================
package eq_pkg;

  localparam int NUM_BINS = 256;       // histogram bins / pixel values
  localparam int ADDR_W   = 16;        // scratchpad address width
  localparam int DATA_W   = 128;       // scratchpad word width
  localparam int CDF_W    = 32;        // cumulative count width
  localparam int CNT_W    = 16;        // per-bin count width

  // Tag in bits [31:16] of a histogram word that marks it as written.
  localparam logic [15:0] MARKER = 16'hAAAA;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } eq_state_e;

endpackage : eq_pkg
`default_nettype wire

// File: rtl/cdf_pipeline_if.sv
`default_nettype none
// ============================================================================
// Module   : cdf_pipeline_if
// Purpose  : Bundles the CDF stage's control, scratchpad and result signals.
// Modports : master - the CDF stage (drives addresses, writes and results)
//            slave  - the surrounding system (drives start and m2 read data)
// Signals  : start, m2ReadVal, m2ReadAddr, m3WriteAddr, m3WriteVal, m3WE,
//            cdfMin, pixelTotal, done
// Revision : 1.0  initial release
// ============================================================================
interface cdf_pipeline_if #(
  parameter int ADDR_W = eq_pkg::ADDR_W,
  parameter int DATA_W = eq_pkg::DATA_W,
  parameter int CDF_W  = eq_pkg::CDF_W
) ();

  logic              start;
  logic [DATA_W-1:0] m2ReadVal;
  logic [ADDR_W-1:0] m2ReadAddr;
  logic [ADDR_W-1:0] m3WriteAddr;
  logic [DATA_W-1:0] m3WriteVal;
  logic              m3WE;
  logic [CDF_W-1:0]  cdfMin;
  logic [CDF_W-1:0]  pixelTotal;
  logic              done;

  modport master (
    input  start, m2ReadVal,
    output m2ReadAddr, m3WriteAddr, m3WriteVal, m3WE, cdfMin, pixelTotal, done
  );

  modport slave (
    output start, m2ReadVal,
    input  m2ReadAddr, m3WriteAddr, m3WriteVal, m3WE, cdfMin, pixelTotal, done
  );

endinterface : cdf_pipeline_if
`default_nettype wire

// File: rtl/cdf_bin_decode.sv
`default_nettype none
// ============================================================================
// Module   : cdf_bin_decode
// Purpose  : Combinational extraction of a bin count from a histogram word.
//            With CDF_MARKER_CHECK_EN defined, a word whose tag [31:16] is
//            not MARKER is stale and decodes as an empty bin. Without it the
//            low 16 bits are taken as-is (m2 must be zero-initialised).
// Macro    : CDF_MARKER_CHECK_EN
// Ports    : i_word  [DATA_W-1:0]  histogram word read from m2
//            o_count [CNT_W-1:0]   bin count
// Revision : 1.0  initial release
// ============================================================================
module cdf_bin_decode #(
  parameter int          DATA_W = eq_pkg::DATA_W,
  parameter logic [15:0] MARKER = eq_pkg::MARKER
) (
  input  logic [DATA_W-1:0]        i_word,
  output logic [eq_pkg::CNT_W-1:0] o_count
);

  import eq_pkg::*;

`ifdef CDF_MARKER_CHECK_EN
  logic w_tag_ok;
  logic w_unused_hi;

  assign w_tag_ok    = (i_word[31:16] == MARKER);
  assign o_count     = w_tag_ok ? i_word[CNT_W-1:0] : '0;
  assign w_unused_hi = ^i_word[DATA_W-1:32];
`else
  logic w_unused_hi;

  assign o_count     = i_word[CNT_W-1:0];
  assign w_unused_hi = ^{i_word[DATA_W-1:CNT_W], MARKER};
`endif

endmodule : cdf_bin_decode
`default_nettype wire

// File: rtl/cdf_pipeline.sv
`default_nettype none
// ============================================================================
// Module   : cdf_pipeline
// Purpose  : Streams all histogram bins out of m2, accumulates the CDF and
//            writes each value to m3 at the same bin address; reports the
//            first non-zero CDF value and the total pixel count.
//            Pipeline: address (stage 1) -> decode (stage 2) ->
//            accumulate (stage 3) -> m3 write register.
// Macro    : CDF_MARKER_CHECK_EN (marker check inside cdf_bin_decode)
// Ports    : clock  system clock, rising edge
//            rst_n  asynchronous active-low reset
//            bus    cdf_pipeline_if.master (start, m2 read, m3 write,
//                   cdfMin, pixelTotal, done)
// Revision : 1.0  initial release
// ============================================================================
module cdf_pipeline #(
  parameter int          NUM_BINS = eq_pkg::NUM_BINS,
  parameter int          ADDR_W   = eq_pkg::ADDR_W,
  parameter int          DATA_W   = eq_pkg::DATA_W,
  parameter logic [15:0] MARKER   = eq_pkg::MARKER
) (
  input  logic            clock,
  input  logic            rst_n,
  cdf_pipeline_if.master  bus
);

  import eq_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_BIN = ADDR_W'(NUM_BINS - 1);

  eq_state_e          r_state;
  logic [ADDR_W-1:0]  r_issue;      // next bin address to issue
  logic [ADDR_W-1:0]  r_m2_addr;    // stage 1: registered read address
  logic               r_v1;
  logic [ADDR_W-1:0]  r_a2;         // stage 2: decoded count
  logic [CNT_W-1:0]   r_cnt2;
  logic               r_v2;
  logic [ADDR_W-1:0]  r_a3;         // stage 3: accumulated cdf
  logic               r_v3;
  logic [CDF_W-1:0]   r_cdf;
  logic [CDF_W-1:0]   r_min;
  logic               r_found;
  logic [ADDR_W-1:0]  r_wr_addr;
  logic [DATA_W-1:0]  r_wr_val;
  logic               r_we;
  logic [CDF_W-1:0]   r_cdf_min_o;
  logic [CDF_W-1:0]   r_total;
  logic               r_done;

  logic [CNT_W-1:0]   w_count;
  logic [CDF_W-1:0]   w_cdf_next;
  logic               w_drained;

  cdf_bin_decode #(
    .DATA_W (DATA_W),
    .MARKER (MARKER)
  ) u_decode (
    .i_word  (bus.m2ReadVal),
    .o_count (w_count)
  );

  assign w_cdf_next = r_cdf + CDF_W'(r_cnt2);
  assign w_drained  = !r_v1 && !r_v2 && !r_v3;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_issue     <= '0;
      r_m2_addr   <= '0;
      r_v1        <= 1'b0;
      r_a2        <= '0;
      r_cnt2      <= '0;
      r_v2        <= 1'b0;
      r_a3        <= '0;
      r_v3        <= 1'b0;
      r_cdf       <= '0;
      r_min       <= '0;
      r_found     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_val    <= '0;
      r_we        <= 1'b0;
      r_cdf_min_o <= '0;
      r_total     <= '0;
      r_done      <= 1'b0;
    end else begin
      // Data stages advance every cycle; only the valid bits gate updates.
      r_v2 <= r_v1;
      if (r_v1) begin
        r_a2   <= r_m2_addr;
        r_cnt2 <= w_count;
      end

      r_v3 <= r_v2;
      if (r_v2) begin
        r_a3  <= r_a2;
        r_cdf <= w_cdf_next;
        // The cdf is monotonic, so the first non-zero sum is the minimum.
        if (!r_found && (w_cdf_next != '0)) begin
          r_found <= 1'b1;
          r_min   <= w_cdf_next;
        end
      end

      r_we <= r_v3;
      if (r_v3) begin
        r_wr_addr <= r_a3;
        r_wr_val  <= {{(DATA_W-CDF_W){1'b0}}, r_cdf};
      end

      r_v1 <= 1'b0;

      case (r_state)
        S_IDLE, S_DONE: begin
          // Pipeline is empty here, so clearing the accumulator is safe.
          if (bus.start) begin
            r_state <= S_RUN;
            r_issue <= '0;
            r_cdf   <= '0;
            r_min   <= '0;
            r_found <= 1'b0;
          end
        end
        S_RUN: begin
          // Results of the previous pass drop on the first issue cycle.
          r_done      <= 1'b0;
          r_cdf_min_o <= '0;
          r_total     <= '0;
          r_m2_addr   <= r_issue;
          r_v1        <= 1'b1;
          r_issue     <= r_issue + ADDR_W'(1);
          if (r_issue == LAST_BIN) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // Last write has been registered once every stage is empty.
          if (w_drained) begin
            r_state     <= S_DONE;
            r_done      <= 1'b1;
            r_cdf_min_o <= r_min;
            r_total     <= r_cdf;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.m2ReadAddr  = r_m2_addr;
  assign bus.m3WriteAddr = r_wr_addr;
  assign bus.m3WriteVal  = r_wr_val;
  assign bus.m3WE        = r_we;
  assign bus.cdfMin      = r_cdf_min_o;
  assign bus.pixelTotal  = r_total;
  assign bus.done        = r_done;

endmodule : cdf_pipeline
`default_nettype wire

// File: tb/tb_cdf_pipeline.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdf_pipeline
// Purpose  : Self-checking bench for cdf_pipeline. A reference CDF is built
//            from the m2 image with a plain running sum; a negedge process
//            compares every output against the cycle-indexed expectation of
//            a pass, and literal values pin the results of each scenario.
// Macro    : CDF_MARKER_CHECK_EN (selects the expected decode rule)
// Revision : 1.0  initial release
// ============================================================================
module tb_cdf_pipeline;

  import eq_pkg::*;

  logic clock = 1'b0;
  logic rst_n = 1'b1;

  always #5 clock = ~clock;

  cdf_pipeline_if bus ();

  cdf_pipeline dut (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  logic [DATA_W-1:0] m2      [0:NUM_BINS-1];
  logic [31:0]       m3_cap  [0:NUM_BINS-1];
  logic [31:0]       exp_cdf [0:NUM_BINS-1];
  logic [31:0]       exp_min;
  logic [31:0]       exp_total;

  int n_cmp  = 0;
  int n_bad  = 0;
  int k_edge = 0;
  bit tracking = 1'b0;

  // m2 answers combinationally for the registered read address.
  assign bus.m2ReadVal = m2[bus.m2ReadAddr[7:0]];

  // m3 memory image as seen by a write port.
  always @(posedge clock) begin
    if (bus.m3WE) m3_cap[bus.m3WriteAddr[7:0]] = bus.m3WriteVal[31:0];
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] bin_count(input logic [DATA_W-1:0] w);
`ifdef CDF_MARKER_CHECK_EN
    return (w[31:16] == 16'hAAAA) ? {16'h0, w[15:0]} : 32'h0;
`else
    return {16'h0, w[15:0]};
`endif
  endfunction

  task automatic build_model();
    logic [31:0] run;
    bit found;
    run = 0;
    found = 0;
    exp_min = 0;
    for (int a = 0; a < NUM_BINS; a++) begin
      run = run + bin_count(m2[a]);
      exp_cdf[a] = run;
      if (!found && run != 0) begin
        found = 1;
        exp_min = run;
      end
    end
    exp_total = run;
  endtask

  // Cycle-indexed expectation of a pass: k_edge is the edge number after
  // the start-sampling edge E0.
  always @(negedge clock) begin
    if (tracking && k_edge >= 1) begin
      if (k_edge <= NUM_BINS)
        chk("m2ReadAddr", 128'(bus.m2ReadAddr), 128'(k_edge - 1));
      chk("m3WE", 128'(bus.m3WE), 128'(k_edge >= 4 && k_edge <= NUM_BINS + 3));
      if (k_edge >= 4 && k_edge <= NUM_BINS + 3) begin
        chk("m3WriteAddr", 128'(bus.m3WriteAddr), 128'(k_edge - 4));
        chk("m3WriteVal", bus.m3WriteVal, {96'b0, exp_cdf[k_edge - 4]});
      end
      chk("done", 128'(bus.done), 128'(k_edge >= NUM_BINS + 4));
      if (k_edge >= NUM_BINS + 4) begin
        chk("cdfMin", 128'(bus.cdfMin), 128'(exp_min));
        chk("pixelTotal", 128'(bus.pixelTotal), 128'(exp_total));
      end
    end
  end

  task automatic run_pass(input int pulse_at, input int abort_at, input bit from_done);
    build_model();
    for (int a = 0; a < NUM_BINS; a++) m3_cap[a] = 32'hDEADBEEF;
    @(negedge clock);
    bus.start = 1'b1;
    @(posedge clock);
    #2;
    bus.start = 1'b0;
    if (from_done) chk("done_held_at_E0", 128'(bus.done), 128'(1));
    k_edge = 0;
    tracking = 1'b1;
    for (int k = 1; k <= NUM_BINS + 6; k++) begin
      @(posedge clock);
      k_edge = k;
      if (k == abort_at) begin
        tracking = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_m3WE", 128'(bus.m3WE), 128'(0));
        chk("abort_done", 128'(bus.done), 128'(0));
        chk("abort_m2ReadAddr", 128'(bus.m2ReadAddr), 128'(0));
        @(negedge clock);
        @(negedge clock);
        rst_n = 1'b1;
        return;
      end
      #2;
      bus.start = (k == pulse_at);
    end
    tracking = 1'b0;
    bus.start = 1'b0;
  endtask

  task automatic fill_m2(input logic [15:0] tag, input logic [15:0] cnt);
    for (int a = 0; a < NUM_BINS; a++) m2[a] = {96'b0, tag, cnt};
  endtask

  initial begin
    bus.start = 1'b0;
    fill_m2(16'h0000, 16'h0000);
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_m2ReadAddr", 128'(bus.m2ReadAddr), 128'(0));
    chk("rst_m3WriteAddr", 128'(bus.m3WriteAddr), 128'(0));
    chk("rst_m3WriteVal", bus.m3WriteVal, 128'(0));
    chk("rst_m3WE", 128'(bus.m3WE), 128'(0));
    chk("rst_cdfMin", 128'(bus.cdfMin), 128'(0));
    chk("rst_pixelTotal", 128'(bus.pixelTotal), 128'(0));
    chk("rst_done", 128'(bus.done), 128'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clock);
    chk("idle_m3WE", 128'(bus.m3WE), 128'(0));

    // All bins empty.
    run_pass(0, 0, 1'b0);
    chk("zero_total", 128'(bus.pixelTotal), 128'(0));
    chk("zero_min", 128'(bus.cdfMin), 128'(0));
    chk("zero_m3_0", 128'(m3_cap[0]), 128'(0));
    chk("zero_m3_255", 128'(m3_cap[255]), 128'(0));

    // Single populated bin.
    m2[37] = {96'b0, 16'hAAAA, 16'h0010};
    run_pass(0, 0, 1'b1);
    chk("b37_m3_36", 128'(m3_cap[36]), 128'(0));
    chk("b37_m3_37", 128'(m3_cap[37]), 128'(32'h10));
    chk("b37_m3_255", 128'(m3_cap[255]), 128'(32'h10));
    chk("b37_min", 128'(bus.cdfMin), 128'(32'h10));
    chk("b37_total", 128'(bus.pixelTotal), 128'(32'h10));

    // Every bin holds 1; start pulsed mid-RUN must be ignored.
    fill_m2(16'hAAAA, 16'h0001);
    run_pass(50, 0, 1'b1);
    chk("ones_m3_0", 128'(m3_cap[0]), 128'(1));
    chk("ones_m3_99", 128'(m3_cap[99]), 128'(100));
    chk("ones_m3_255", 128'(m3_cap[255]), 128'(256));
    chk("ones_min", 128'(bus.cdfMin), 128'(1));
    chk("ones_total", 128'(bus.pixelTotal), 128'(256));

    // Restart from DONE with the same image.
    run_pass(0, 0, 1'b1);
    chk("rerun_m3_128", 128'(m3_cap[128]), 128'(129));
    chk("rerun_total", 128'(bus.pixelTotal), 128'(256));

    // Maximum counts: largest possible sum.
    fill_m2(16'hAAAA, 16'hFFFF);
    run_pass(0, 0, 1'b1);
    chk("max_m3_0", 128'(m3_cap[0]), 128'(32'h0000FFFF));
    chk("max_m3_255", 128'(m3_cap[255]), 128'(32'h00FFFF00));
    chk("max_min", 128'(bus.cdfMin), 128'(32'h0000FFFF));

    // Wrong tag on bin 5.
    fill_m2(16'h0000, 16'h0000);
    m2[5]  = {96'b0, 16'h5555, 16'h0007};
    m2[10] = {96'b0, 16'hAAAA, 16'h0003};
    run_pass(0, 0, 1'b1);
`ifdef CDF_MARKER_CHECK_EN
    chk("tag_m3_5", 128'(m3_cap[5]), 128'(0));
    chk("tag_m3_10", 128'(m3_cap[10]), 128'(3));
    chk("tag_min", 128'(bus.cdfMin), 128'(3));
    chk("tag_total", 128'(bus.pixelTotal), 128'(3));
`else
    chk("tag_m3_5", 128'(m3_cap[5]), 128'(7));
    chk("tag_m3_10", 128'(m3_cap[10]), 128'(10));
    chk("tag_min", 128'(bus.cdfMin), 128'(7));
    chk("tag_total", 128'(bus.pixelTotal), 128'(10));
`endif

    // Reset mid-pass, then a clean pass from IDLE.
    fill_m2(16'hAAAA, 16'h0001);
    run_pass(0, 100, 1'b1);
    run_pass(0, 0, 1'b0);
    chk("post_abort_m3_255", 128'(m3_cap[255]), 128'(256));
    chk("post_abort_total", 128'(bus.pixelTotal), 128'(256));
    chk("post_abort_min", 128'(bus.cdfMin), 128'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_cdf_pipeline
`default_nettype wire
